// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding, error codes and frame constants for the IMEM boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_SIZE = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    localparam int HDR_BYTES = 2;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a little-endian byte stream into 32-bit words with a one-cycle word_valid pulse.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_ni,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic        last_o,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] asm_q, asm_d;
    logic [31:0] word_q, word_d;
    logic        wv_q;

    assign last_o       = valid_i && cnt_q == 2'd3;
    assign word_o       = word_q;
    assign word_valid_o = wv_q;

    // Earlier bytes drift down so the first byte ends up least significant.
    always_comb begin
        cnt_d  = valid_i ? cnt_q + 2'd1 : cnt_q;
        asm_d  = valid_i ? {byte_i, asm_q[23:8]} : asm_q;
        word_d = last_o ? {byte_i, asm_q} : word_q;
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            asm_q  <= '0;
            word_q <= '0;
            wv_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            asm_q  <= asm_d;
            word_q <= word_d;
            wv_q   <= last_o;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a checksummed byte-stream image into IMEM and holds the core in reset until it verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_WORDS  = 256,
    parameter int START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              restart,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CW = ADDR_W + 1;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              hold_q, hold_d;
    logic [1:0]        err_q, err_d;
    logic [7:0]        cnt_lo_q, cnt_lo_d;
    logic [7:0]        acc_q, acc_d;
    logic [CW-1:0]     n_q, n_d;
    logic [CW-1:0]     words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              accept, word_last, size_bad;
    logic [15:0]       n_full;

    assign accept   = in_valid && in_ready_q;
    assign n_full   = {in_data, cnt_lo_q};
    assign size_bad = 32'(n_full) > MAX_WORDS;

    assign in_ready     = in_ready_q;
    assign mem_addr     = addr_q;
    assign cpu_hold     = hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_q;
    assign words_loaded = words_q;

    word_assembler u_asm (
        .clk          (clk),
        .rst_ni       (reset),
        .byte_i       (in_data),
        .valid_i      (accept && state_q == DATA),
        .last_o       (word_last),
        .word_o       (mem_wdata),
        .word_valid_o (mem_we)
    );

    always_comb begin
        state_d  = state_q;
        cnt_lo_d = cnt_lo_q;
        n_d      = n_q;
        acc_d    = acc_q;
        err_d    = err_q;
        words_d  = word_last ? words_q + CW'(1) : words_q;
        addr_d   = word_last ? ADDR_W'(START_ADDR) + words_q[ADDR_W-1:0] : addr_q;
        case (state_q)
            HDR0: if (accept) begin
                cnt_lo_d = in_data;
                acc_d    = acc_q ^ in_data;
                state_d  = HDR1;
            end
            HDR1: if (accept) begin
                acc_d   = acc_q ^ in_data;
                n_d     = CW'(n_full);
                err_d   = size_bad ? ERR_SIZE : ERR_NONE;
                state_d = size_bad ? ERR : n_full == 16'd0 ? CSUM : DATA;
            end
            DATA: begin
                acc_d   = accept ? acc_q ^ in_data : acc_q;
                state_d = (word_last && words_q + CW'(1) == n_q) ? CSUM : DATA;
            end
            CSUM: if (accept) begin
                err_d   = in_data == acc_q ? ERR_NONE : ERR_CSUM;
                state_d = in_data == acc_q ? DONE : ERR;
            end
            default: if (restart) begin
                state_d = HDR0;
                err_d   = ERR_NONE;
                words_d = '0;
                acc_d   = '0;
            end
        endcase
        in_ready_d = state_d inside {HDR0, HDR1, DATA, CSUM};
        done_d     = state_d == DONE;
        error_d    = state_d == ERR;
        hold_d     = state_d != DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= HDR0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b1;
            err_q      <= ERR_NONE;
            cnt_lo_q   <= '0;
            acc_q      <= '0;
            n_q        <= '0;
            words_q    <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            error_q    <= error_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            cnt_lo_q   <= cnt_lo_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven frame loads plus hand sequences for restart and mid-frame reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        restart = 1'b0;
    logic        in_ready, mem_we, cpu_hold, done, error;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  err_code;
    logic [8:0]  words_loaded;

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256), .START_ADDR(0)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .restart      (restart),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [7:0]  b[12];
        bit          gap;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_words;
        logic [31:0] exp_w[2];
    } vec_t;

    vec_t        vecs[6];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  wr_addr[8];
    logic [31:0] wr_data[8];
    int          wr_n = 0;

    // Each write strobe is seen on exactly one falling edge when it lasts one cycle.
    always @(negedge clk) if (mem_we === 1'b1) begin
        if (wr_n < 8) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
        end
        wr_n++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        int k = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=%0h expected=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 1);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_error"}, 32'(error), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_words"}, 32'(words_loaded), 0);
    endtask

    task automatic chk_writes(input string tag, input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] w[2];
        w[0] = w0;
        w[1] = w1;
        chk({tag, "_write_count"}, 32'(wr_n), 32'(n));
        for (int j = 0; j < n && j < wr_n; j++) begin
            chk($sformatf("%s_addr%0d", tag, j), 32'(wr_addr[j]), 32'(j));
            chk($sformatf("%s_data%0d", tag, j), wr_data[j], w[j]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{11, '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h43, 8'h00},
                    1'b0, 1'b1, 1'b0, 2'b00, 2, '{32'h00500093, 32'h00108113}};
        vecs[1] = '{3, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1'b0, 1'b1, 1'b0, 2'b00, 0, '{32'h0, 32'h0}};
        vecs[2] = '{2, '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1'b0, 1'b0, 1'b1, 2'b01, 0, '{32'h0, 32'h0}};
        vecs[3] = '{11, '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h44, 8'h00},
                    1'b0, 1'b0, 1'b1, 2'b10, 2, '{32'h00500093, 32'h00108113}};
        vecs[4] = '{7, '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h23, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    1'b0, 1'b1, 1'b0, 2'b00, 1, '{32'hDEADBEEF, 32'h0}};
        vecs[5] = '{11, '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h81, 8'h10, 8'h00, 8'h43, 8'h00},
                    1'b1, 1'b1, 1'b0, 2'b00, 2, '{32'h00500093, 32'h00108113}};

        #12;
        chk_reset_vals("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk);
                restart = 1'b1;
                @(negedge clk);
                restart = 1'b0;
                chk($sformatf("v%0d_rs_hold", i), 32'(cpu_hold), 1);
                chk($sformatf("v%0d_rs_done", i), 32'(done), 0);
                chk($sformatf("v%0d_rs_error", i), 32'(error), 0);
                chk($sformatf("v%0d_rs_code", i), 32'(err_code), 0);
                chk($sformatf("v%0d_rs_words", i), 32'(words_loaded), 0);
                chk($sformatf("v%0d_rs_ready", i), 32'(in_ready), 1);
            end
            wr_n = 0;
            for (int k = 0; k < vecs[i].len; k++)
                send(vecs[i].b[k], vecs[i].gap ? (k % 3) + 1 : 0);
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].exp_code));
            chk($sformatf("v%0d_hold", i), 32'(cpu_hold), 32'(!vecs[i].exp_done));
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_words", i), 32'(words_loaded), 32'(vecs[i].exp_words));
            chk_writes($sformatf("v%0d", i), vecs[i].exp_words, vecs[i].exp_w[0], vecs[i].exp_w[1]);
        end

        // Ignored input while DONE: no writes, state unchanged.
        wr_n = 0;
        in_data  = 8'h55;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("done_ignore_writes", 32'(wr_n), 0);
        chk("done_ignore_done", 32'(done), 1);

        // Abandon a frame mid-word with an asynchronous reset, then reload cleanly.
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        for (int k = 0; k < 6; k++) send(vecs[0].b[k], 0);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(negedge clk);
        reset = 1'b1;
        wr_n = 0;
        for (int k = 0; k < 11; k++) send(vecs[0].b[k], 0);
        chk("reload_done", 32'(done), 1);
        chk("reload_hold", 32'(cpu_hold), 0);
        repeat (3) @(negedge clk);
        chk("reload_words", 32'(words_loaded), 2);
        chk_writes("reload", 2, 32'h00500093, 32'h00108113);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot loader that fills the single-cycle RISC-V core's instruction memory from a byte stream (e.g. a UART receiver output), then releases the core.
- It is the writer to the instruction memory the core reads. It holds the core in reset (`cpu_hold`) until a complete, checksum-verified image has been written.
- Sits between the byte-source front end and the IMEM write port, one level above `RISC_V`.

Parameters:
- ADDR_W, 8, IMEM word-address width.
- MAX_WORDS, 256, largest accepted image in words; must be ≤ 2^ADDR_W.
- START_ADDR, 0, word address of the first loaded word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte.
- restart  input  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- mem_we  output  1  IMEM write strobe, one cycle per word.
- mem_addr  output  ADDR_W  IMEM word address.
- mem_wdata  output  32  IMEM write data.
- cpu_hold  output  1  high holds the core in reset.
- done  output  1  image loaded and verified.
- error  output  1  load failed.
- err_code  output  2  01 = too many words, 10 = checksum mismatch, 00 = none.
- words_loaded  output  ADDR_W+1  count of words written.

Behaviour:
- Reset values (asynchronous, while reset=0):
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, done=0, error=0, err_code=00, words_loaded=0.
  - Internal: state=HDR0, checksum accumulator=0.
- Transfer rule: a byte is accepted when in_valid & in_ready at a rising clk edge. in_ready is registered; it is 1 in HDR0, HDR1, DATA and CSUM, and 0 in DONE and ERR.
- Frame format:
  - 2-byte word count N, little-endian.
  - N words, 4 bytes each, little-endian.
  - 1 checksum byte equal to the XOR of all preceding frame bytes (header and data).
- HDR0: accept low count byte -> HDR1.
- HDR1: accept high count byte, then branch:
  - N > MAX_WORDS -> ERR, err_code=01.
  - N == 0 -> CSUM.
  - otherwise -> DATA.
- DATA:
  - Bytes shift into a 24-bit assembly register.
  - On acceptance of the 4th byte of a word, these are registered on the same edge:
    - mem_wdata = {byte, asm[23:0]}
    - mem_addr = START_ADDR + word index
  - mem_we is high for exactly the next cycle; words_loaded increments on the edge where mem_we is registered.
  - Back-to-back bytes are allowed and in_ready stays high throughout.
  - After the Nth word -> CSUM.
- CSUM: accept one byte.
  - Equal to accumulator -> DONE.
  - Otherwise -> ERR, err_code=10.
  - The final word's write always completes before the checksum byte can be accepted.
- DONE: on the entry edge, done=1 and cpu_hold=0. All stream input is ignored.
- ERR: error=1, cpu_hold stays 1. Input is ignored.
- restart in DONE or ERR:
  - -> HDR0 next edge.
  - cpu_hold=1, done=0, error=0, err_code=00, words_loaded=0, checksum accumulator cleared.
  - IMEM contents are untouched.
  - restart is ignored in every other state.
- Address arithmetic wraps modulo 2^ADDR_W (START_ADDR + N - 1 may wrap).
- Reset mid-frame: the partial image is abandoned and all outputs return to reset values. The next frame starts at HDR0, and the checksum covers only bytes of the new frame.
- Gaps on in_valid: state and accumulator are held; no spurious mem_we.

Decomposition:
- Package `imem_loader_pkg` holds:
  - state enum: HDR0, HDR1, DATA, CSUM, DONE, ERR
  - err_code constants: ERR_NONE, ERR_SIZE, ERR_CSUM
  - frame header length constant
- One sub-module, `word_assembler`: byte shift register, byte-in-word counter and registered 32-bit output with word_valid pulse.
- FSM, address counter and checksum accumulator stay in `imem_loader`.

Test Plan:
- Load 02 00 93 00 50 00 13 81 10 00 43 ->
  - mem_we at addr 0, wdata 0x00500093; then addr 1, wdata 0x00108113.
  - done=1, cpu_hold=0, words_loaded=2, error=0.
- Load 00 00 00 -> no mem_we, done=1, words_loaded=0.
- Load 01 01 (N=257, MAX_WORDS=256) -> error=1, err_code=01 on the edge after byte 2; in_ready=0; no writes.
- Same as the first scenario but with checksum 44 -> both words written, error=1, err_code=10, cpu_hold=1, done=0.
- Drive reset=0 after 6 bytes of the first frame -> all outputs at reset values. Resending the full first frame then yields done=1 with the correct words.
- Pulse restart in DONE -> cpu_hold=1, done=0, in_ready=1. Load with 1-3 idle cycles between bytes -> identical writes; mem_we is exactly one cycle per word.
